// File: rtl/sbi_pkg.sv
// Shared types and default sizing for the simple burst interface (SBI).
package sbi_pkg;

  localparam int SbiWidth  = 32;
  localparam int SbiDepth  = 256;
  localparam int SbiMaxLen = 16;
  localparam int SbiAw     = $clog2(SbiDepth);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } sbi_state_e;

  // One registered request-side bus cycle, sized by the package defaults.
  typedef struct packed {
    logic [SbiAw-1:0]    addr;
    logic                start;
    logic                access;
    logic                write;
    logic [SbiWidth-1:0] data;
  } sbiReq_t;

endpackage

// File: rtl/sbi_master.sv
// SBI initiator: turns client burst commands into registered SBI bus beats
// and returns read beats as the responder's bVALID strobes arrive.
module sbi_master
  import sbi_pkg::*;
#(
  parameter int Width  = SbiWidth,
  parameter int Depth  = SbiDepth,
  parameter int MaxLen = SbiMaxLen,
  localparam int Aw = $clog2(Depth),
  localparam int Lw = $clog2(MaxLen) + 1
) (
  input  logic             bCLK,
  input  logic             bRSTn,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [Aw-1:0]    cmd_addr_i,
  input  logic [Lw-1:0]    cmd_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             rdata_valid_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [Aw-1:0]    bADDR,
  output logic             bSTART,
  output logic             bACCESS,
  output logic             bWRITE,
  output logic [Width-1:0] bD,
  input  logic [Width-1:0] bQ,
  input  logic             bVALID
);

  localparam logic [Lw-1:0] MaxLenW = Lw'(MaxLen);

  sbi_state_e       state;
  sbiReq_t          busReg;
  logic [Lw-1:0]    burstLen;
  logic [Lw-1:0]    issueCnt;
  logic [Lw-1:0]    recvCnt;
  logic [Width-1:0] rdataReg;
  logic             rdataValidReg;
  logic             doneReg;

  logic [Lw-1:0]    lenClamped;
  logic [Lw-1:0]    issueNext;
  logic [Lw-1:0]    recvNext;
  logic             wdataFire;
  logic             recvFire;

  assign lenClamped = (cmd_len_i > MaxLenW) ? MaxLenW : cmd_len_i;
  assign issueNext  = issueCnt + Lw'(1);
  assign recvNext   = recvCnt + Lw'(1);
  assign wdataFire  = wdata_valid_i && wdata_ready_o;
  // Responses past the programmed length are dropped without any output change.
  assign recvFire   = bVALID && (recvCnt < burstLen);

  assign cmd_ready_o   = (state == IDLE);
  assign busy_o        = (state != IDLE);
  assign wdata_ready_o = (state == WR) && (issueCnt < burstLen);

  assign bADDR   = busReg.addr;
  assign bSTART  = busReg.start;
  assign bACCESS = busReg.access;
  assign bWRITE  = busReg.write;
  assign bD      = busReg.data;

  assign rdata_o       = rdataReg;
  assign rdata_valid_o = rdataValidReg;
  assign done_o        = doneReg;

  always_ff @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) begin
      state         <= IDLE;
      busReg        <= '0;
      burstLen      <= '0;
      issueCnt      <= '0;
      recvCnt       <= '0;
      rdataReg      <= '0;
      rdataValidReg <= 1'b0;
      doneReg       <= 1'b0;
    end else begin
      rdataValidReg <= 1'b0;
      doneReg       <= 1'b0;
      busReg.start  <= 1'b0;
      busReg.access <= 1'b0;

      case (state)
        IDLE: begin
          busReg.write <= 1'b0;
          if (cmd_valid_i) begin
            burstLen <= lenClamped;
            issueCnt <= '0;
            recvCnt  <= '0;
            if (lenClamped == '0) begin
              doneReg <= 1'b1;
            end else if (cmd_write_i) begin
              state        <= WR;
              busReg.addr  <= cmd_addr_i;
              busReg.write <= 1'b1;
            end else begin
              // Reads need no data, so the first beat goes out right away.
              state         <= (lenClamped == Lw'(1)) ? RD_WAIT : RD;
              busReg.addr   <= cmd_addr_i;
              busReg.start  <= 1'b1;
              busReg.access <= 1'b1;
              issueCnt      <= Lw'(1);
            end
          end
        end

        WR: begin
          busReg.write <= 1'b1;
          if (wdataFire) begin
            busReg.data   <= wdata_i;
            busReg.access <= 1'b1;
            busReg.start  <= (issueCnt == '0);
            issueCnt      <= issueNext;
            if (issueNext == burstLen) begin
              state   <= IDLE;
              doneReg <= 1'b1;
            end
          end
        end

        RD, RD_WAIT: begin
          if (state == RD) begin
            busReg.access <= 1'b1;
            issueCnt      <= issueNext;
            if (issueNext == burstLen) state <= RD_WAIT;
          end
          // Completion is decided by returned beats only; it also overrides issuing.
          if (recvFire) begin
            rdataReg      <= bQ;
            rdataValidReg <= 1'b1;
            recvCnt       <= recvNext;
            if (recvNext == burstLen) begin
              state   <= IDLE;
              doneReg <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbi_master.sv
// Scoreboard bench for sbi_master with a behavioural SBI memory responder.
module tb_sbi_master;
  import sbi_pkg::*;

  localparam int Width  = 32;
  localparam int Depth  = 256;
  localparam int MaxLen = 16;
  localparam int Aw     = 8;
  localparam int Lw     = 5;

  logic             bCLK = 1'b0;
  logic             bRSTn = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic             cmd_write_i = 1'b0;
  logic [Aw-1:0]    cmd_addr_i = '0;
  logic [Lw-1:0]    cmd_len_i = '0;
  logic             wdata_valid_i = 1'b0;
  logic             wdata_ready_o;
  logic [Width-1:0] wdata_i = '0;
  logic [Width-1:0] rdata_o;
  logic             rdata_valid_o;
  logic             done_o;
  logic             busy_o;
  logic [Aw-1:0]    bADDR;
  logic             bSTART;
  logic             bACCESS;
  logic             bWRITE;
  logic [Width-1:0] bD;
  logic [Width-1:0] bQ;
  logic             bVALID;

  always #5 bCLK = ~bCLK;

  sbi_master #(.Width(Width), .Depth(Depth), .MaxLen(MaxLen)) dut (
    .bCLK(bCLK), .bRSTn(bRSTn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .done_o(done_o), .busy_o(busy_o),
    .bADDR(bADDR), .bSTART(bSTART), .bACCESS(bACCESS), .bWRITE(bWRITE), .bD(bD),
    .bQ(bQ), .bVALID(bVALID)
  );

  // Responder: pointer loads on bSTART, increments and wraps on later beats, 1-cycle read latency.
  logic [Width-1:0] mem [Depth];
  logic [Aw-1:0]    ptr;
  logic [Aw-1:0]    respAddr;
  logic             respValid;
  logic [Width-1:0] respData;
  logic             spur = 1'b0;
  logic [Width-1:0] spurData = '0;
  logic             preWe = 1'b0;
  logic [Aw-1:0]    preAddr = '0;
  logic [Width-1:0] preData = '0;

  assign respAddr = bSTART ? bADDR : Aw'(ptr + 1'b1);
  assign bVALID   = respValid | spur;
  assign bQ       = spur ? spurData : respData;

  always @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) begin
      ptr       <= '0;
      respValid <= 1'b0;
      respData  <= '0;
    end else begin
      respValid <= 1'b0;
      if (preWe) mem[preAddr] <= preData;
      if (bACCESS) begin
        ptr <= respAddr;
        if (bWRITE) mem[respAddr] <= bD;
        else begin
          respValid <= 1'b1;
          respData  <= mem[respAddr];
        end
      end
    end
  end

  typedef struct {
    logic             start;
    logic [Aw-1:0]    addr;
    logic             write;
    logic             chkData;
    logic [Width-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic [Width-1:0] data;
    logic             last;
  } rd_t;

  beat_t expBeats[$];
  rd_t   expRd[$];
  int    expBare = 0;
  int    nChecks = 0;
  int    nFails  = 0;
  bit    sbOn    = 1'b0;
  beat_t e;
  rd_t   r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bus beat, read beat and bare done pulse is matched against the queues.
  always @(negedge bCLK) begin
    if (sbOn && bRSTn) begin
      if (bACCESS) begin
        if (expBeats.size() == 0) check("beat_unexpected", 64'(bADDR), 64'hFFFF);
        else begin
          e = expBeats.pop_front();
          $display("beat addr=%0h start=%0b write=%0b data=%0h done=%0b", bADDR, bSTART, bWRITE, bD, done_o);
          check("beat_start", 64'(bSTART), 64'(e.start));
          check("beat_addr", 64'(bADDR), 64'(e.addr));
          check("beat_write", 64'(bWRITE), 64'(e.write));
          if (e.chkData) check("beat_data", 64'(bD), 64'(e.data));
          check("beat_done", 64'(done_o), 64'(e.last));
        end
      end
      if (rdata_valid_o) begin
        if (expRd.size() == 0) check("rdata_unexpected", 64'(rdata_o), 64'hFFFF);
        else begin
          r = expRd.pop_front();
          $display("rdata=%0h done=%0b", rdata_o, done_o);
          check("rdata", 64'(rdata_o), 64'(r.data));
          check("rdata_done", 64'(done_o), 64'(r.last));
        end
      end
      if (done_o && !bACCESS && !rdata_valid_o) begin
        $display("bare done");
        check("done_bare_expected", 64'(expBare > 0), 64'd1);
        if (expBare > 0) expBare--;
      end
    end
  end

  task automatic sendCmd(input logic wr, input logic [Aw-1:0] addr, input logic [Lw-1:0] len);
    int n = 0;
    @(negedge bCLK);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    while (!cmd_ready_o && n < 50) begin
      @(negedge bCLK);
      n++;
    end
    if (n >= 50) check("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge bCLK);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic writeBurst(input logic [Aw-1:0] addr, input logic [Lw-1:0] len, input int nBeats,
                            input logic [Width-1:0] base, input logic [15:0] pat, input int patLen);
    int k = 0;
    int cyc = 0;
    logic hs;
    for (int i = 0; i < nBeats; i++)
      expBeats.push_back('{start: (i == 0), addr: addr, write: 1'b1, chkData: 1'b1,
                           data: base + Width'(i), last: (i == nBeats - 1)});
    sendCmd(1'b1, addr, len);
    while (k < nBeats && cyc < 200) begin
      @(negedge bCLK);
      wdata_valid_i = (patLen == 0) ? 1'b1 : pat[cyc % patLen];
      wdata_i = base + Width'(k);
      #1 hs = wdata_valid_i && wdata_ready_o;
      @(posedge bCLK);
      if (hs) k++;
      cyc++;
    end
    if (k < nBeats) check("wdata_timeout", 64'(k), 64'(nBeats));
    @(negedge bCLK);
    wdata_valid_i = 1'b0;
  endtask

  task automatic pushReadBeats(input logic [Aw-1:0] addr, input int n);
    for (int i = 0; i < n; i++)
      expBeats.push_back('{start: (i == 0), addr: addr, write: 1'b0, chkData: 1'b0,
                           data: '0, last: 1'b0});
  endtask

  task automatic preload(input logic [Aw-1:0] addr, input logic [Width-1:0] data);
    @(negedge bCLK);
    preWe = 1'b1; preAddr = addr; preData = data;
    @(posedge bCLK);
    #1 preWe = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    do begin
      @(negedge bCLK);
      #2 n++;
    end while ((expBeats.size() != 0 || expRd.size() != 0 || expBare != 0 || !cmd_ready_o) && n < maxCyc);
    if (expBeats.size() != 0 || expRd.size() != 0 || expBare != 0 || !cmd_ready_o)
      check("idle_timeout", 64'(expBeats.size() + expRd.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_wdata_ready"}, 64'(wdata_ready_o), 64'd0);
    check({tag, "_rdata_valid"}, 64'(rdata_valid_o), 64'd0);
    check({tag, "_rdata"}, 64'(rdata_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_bus_ctrl"}, 64'({bSTART, bACCESS, bWRITE}), 64'd0);
    check({tag, "_baddr"}, 64'(bADDR), 64'd0);
    check({tag, "_bd"}, 64'(bD), 64'd0);
  endtask

  initial begin
    logic hs;
    int k;
    int n;

    repeat (3) @(negedge bCLK);
    checkResetOutputs("reset");
    bRSTn = 1'b1;
    sbOn = 1'b1;

    // Write 0x10, len 4, data always valid.
    writeBurst(8'h10, 5'd4, 4, 32'hA0, 16'h0, 0);
    waitIdle(50);

    // Write with valid pattern 1,0,0,1,1,0,1 (LSB first).
    writeBurst(8'h20, 5'd4, 4, 32'hB0, 16'b1011001, 7);
    waitIdle(50);

    // Read wrapping across the top of the address space.
    preload(8'hFE, 32'd1);
    preload(8'hFF, 32'd2);
    preload(8'h00, 32'd3);
    preload(8'h01, 32'd4);
    for (int i = 0; i < 4; i++) expRd.push_back('{data: Width'(i + 1), last: (i == 3)});
    pushReadBeats(8'hFE, 4);
    sendCmd(1'b0, 8'hFE, 5'd4);
    waitIdle(50);

    // Back-to-back: write len 2 then a held read command of the same data.
    expBeats.push_back('{start: 1'b1, addr: 8'h40, write: 1'b1, chkData: 1'b1, data: 32'hC0, last: 1'b0});
    expBeats.push_back('{start: 1'b0, addr: 8'h40, write: 1'b1, chkData: 1'b1, data: 32'hC1, last: 1'b1});
    pushReadBeats(8'h40, 2);
    expRd.push_back('{data: 32'hC0, last: 1'b0});
    expRd.push_back('{data: 32'hC1, last: 1'b1});
    @(negedge bCLK);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 8'h40; cmd_len_i = 5'd2;
    wdata_valid_i = 1'b1; wdata_i = 32'hC0;
    @(posedge bCLK);
    #1 cmd_write_i = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      @(negedge bCLK);
      wdata_i = 32'hC0 + Width'(k);
      #1 hs = wdata_ready_o;
      @(posedge bCLK);
      if (hs) k++;
      n++;
    end
    @(negedge bCLK);
    wdata_valid_i = 1'b0;
    check("b2b_done_on_last_wbeat", 64'(done_o), 64'd1);
    check("b2b_ready_on_last_wbeat", 64'(cmd_ready_o), 64'd1);
    @(posedge bCLK);
    #1 cmd_valid_i = 1'b0;
    @(negedge bCLK);
    check("b2b_read_start", 64'({bSTART, bACCESS, bWRITE}), 64'b110);
    waitIdle(50);

    // Zero-length command: done one cycle after accept, no bus activity.
    expBare = 1;
    sendCmd(1'b1, 8'h33, 5'd0);
    @(negedge bCLK);
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_no_access", 64'(bACCESS), 64'd0);
    @(negedge bCLK);
    check("len0_done_single", 64'(done_o), 64'd0);
    waitIdle(20);

    // Spurious bVALID while idle must not produce a read beat.
    @(negedge bCLK);
    spur = 1'b1; spurData = 32'hDEAD;
    @(negedge bCLK);
    spur = 1'b0;
    check("spurious_no_rdata", 64'(rdata_valid_o), 64'd0);

    // Over-long command is clamped to MaxLen beats.
    writeBurst(8'h80, 5'd20, MaxLen, 32'hD000, 16'h0, 0);
    waitIdle(80);

    // Reset in the middle of a len 8 read.
    sbOn = 1'b0;
    sendCmd(1'b0, 8'h10, 5'd8);
    repeat (3) @(negedge bCLK);
    #2 bRSTn = 1'b0;
    #1 checkResetOutputs("midreset");
    repeat (2) begin
      @(negedge bCLK);
      check("midreset_no_done", 64'(done_o), 64'd0);
    end
    bRSTn = 1'b1;
    @(negedge bCLK);
    check("post_reset_ready", 64'(cmd_ready_o), 64'd1);
    check("post_reset_no_done", 64'(done_o), 64'd0);

    // Single-beat read after reset returns earlier written data.
    sbOn = 1'b1;
    pushReadBeats(8'h40, 1);
    expRd.push_back('{data: 32'hC0, last: 1'b1});
    sendCmd(1'b0, 8'h40, 5'd1);
    waitIdle(30);

    check("queues_empty", 64'(expBeats.size() + expRd.size() + expBare), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
